// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: segment bit order,
// the sixteen hex glyphs and the nibble-to-glyph decoder.
// Segment vectors are {a,b,c,d,e,f,g} with segment a in bit 6; 1 = lit.
package seg_pkg;

  // Bit positions of each segment inside a 7-bit glyph vector
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam int SEG_W = 7;

  // All segments dark
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Hex glyphs, active-high; b and d use the lowercase shapes
  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

  // Decode one hex nibble to its active-high glyph
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] glyph;
    case (nib)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      4'hF:    glyph = GLYPH_F;
      default: glyph = SEG_OFF;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timing for seg_scan_display: free-running prescaler, digit scan
// index, frame-boundary strobe and the PWM brightness gate. Produces
// enables only; no derived clocks.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned PRESCALE_W = 12,
  parameter int unsigned BRIGHT_W   = 3,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [IDX_W-1:0]    idx,
  output logic                frame_end,
  output logic                on
);

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] pre_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  slot_end_s;
  logic                  frame_end_s;
  logic                  on_s;

  // Prescaler: wraps every 2^PRESCALE_W clocks, marking the end of a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= PRE_ZERO;
    end else begin
      pre_r <= pre_r + PRE_ONE;
    end
  end

  // Scan index: step to the next digit at every slot end, wrapping after the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= IDX_ZERO;
    end else if (slot_end_s) begin
      if (idx_r == LAST_IDX) begin
        idx_r <= IDX_ZERO;
      end else begin
        idx_r <= idx_r + IDX_ONE;
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  // Slot/frame strobes and brightness gate from the current counter state
  always_comb begin
    slot_end_s  = &pre_r;
    frame_end_s = 1'b0;
    if (slot_end_s && (idx_r == LAST_IDX)) begin
      frame_end_s = 1'b1;
    end else begin
      frame_end_s = 1'b0;
    end
    // Top BRIGHT_W bits of the prescaler sweep the slot in 2^BRIGHT_W equal
    // steps; the digit is lit for steps 0..brightness.
    on_s = (pre_r[PRESCALE_W-1 -: BRIGHT_W] <= brightness);
  end

  assign idx       = idx_r;
  assign frame_end = frame_end_s;
  assign on        = on_s;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment display driver.
// Latches a packed hex value, scans DIGITS common-enable digits one slot
// at a time, gates each slot with PWM brightness and only swaps the shown
// value at the frame boundary so a frame never mixes old and new digits.
// Optional build macro: SEG_LZB_EN enables leading-zero blanking.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE_W     = 12,
  parameter int unsigned BRIGHT_W       = 3,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          EN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // XOR masks that map active-high internal levels onto the pin polarity;
  // they are also the "all inactive" reset levels of the output registers
  localparam logic [6:0]        SEG_INV  = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic [DIGITS-1:0] EN_INV   = EN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [DIGITS-1:0] EN_ONE   = DIGITS'(1);
  localparam logic [4*DIGITS-1:0] VAL_ZERO = {(4*DIGITS){1'b0}};

  logic [IDX_W-1:0]    idx_s;
  logic                frame_end_s;
  logic                on_s;

  logic [4*DIGITS-1:0] pending_r;
  logic                pend_v_r;
  logic [4*DIGITS-1:0] disp_r;

  logic [3:0]          nib_s;
  logic [6:0]          glyph_s;
  logic [6:0]          seg_next_s;
  logic [DIGITS-1:0]   en_next_s;

  seg_scan_timer #(
    .DIGITS     (DIGITS),
    .PRESCALE_W (PRESCALE_W),
    .BRIGHT_W   (BRIGHT_W),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .brightness (brightness),
    .idx        (idx_s),
    .frame_end  (frame_end_s),
    .on         (on_s)
  );

  // Load buffering: remember the most recent load until the next frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= VAL_ZERO;
    end else if (load) begin
      pending_r <= value;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Tear-free commit: disp changes only at the frame boundary; a load in the
  // boundary cycle itself bypasses the buffer and commits immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_r   <= VAL_ZERO;
      pend_v_r <= 1'b0;
    end else if (frame_end_s) begin
      if (load) begin
        disp_r <= value;
      end else if (pend_v_r) begin
        disp_r <= pending_r;
      end else begin
        disp_r <= disp_r;
      end
      pend_v_r <= 1'b0;
    end else if (load) begin
      disp_r   <= disp_r;
      pend_v_r <= 1'b1;
    end else begin
      disp_r   <= disp_r;
      pend_v_r <= pend_v_r;
    end
  end

  // Glyph decode of the nibble belonging to the digit currently scanned
  always_comb begin
    nib_s   = disp_r[4*idx_s +: 4];
    glyph_s = hex_to_seg(nib_s);
  end

`ifdef SEG_LZB_EN
  logic [DIGITS-1:0] lead_zero_s;
  logic              blank_s;

  // Leading-zero map: bit k is set when nibbles DIGITS-1 down to k are all zero
  always_comb begin : lzb_scan
    logic run;
    run         = 1'b1;
    lead_zero_s = {DIGITS{1'b0}};
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run            = run & (disp_r[4*k +: 4] == 4'h0);
      lead_zero_s[k] = run;
    end
  end

  // Blank leading zeros, but always keep digit 0 so zero still reads "0"
  always_comb begin
    blank_s    = lead_zero_s[idx_s] & (idx_s != {IDX_W{1'b0}});
    seg_next_s = SEG_OFF;
    if (blank_s) begin
      seg_next_s = SEG_OFF;
    end else begin
      seg_next_s = glyph_s;
    end
  end
`else
  // Every digit shows its glyph
  always_comb begin
    seg_next_s = glyph_s;
  end
`endif

  // One-hot enable for the scanned digit, gated by the brightness PWM
  always_comb begin
    en_next_s = {DIGITS{1'b0}};
    if (on_s) begin
      en_next_s = EN_ONE << idx_s;
    end else begin
      en_next_s = {DIGITS{1'b0}};
    end
  end

  // Output registers: seg and dig_en switch on the same edge, so no overlap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_INV;
      dig_en     <= EN_INV;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next_s ^ SEG_INV;
      dig_en     <= en_next_s ^ EN_INV;
      frame_done <= frame_end_s;
    end
  end

endmodule
